// File: rtl/clm_output_stage_pkg.sv
// clm_output_stage_pkg: shared types and constants for the CLM output stage.
package clm_output_stage_pkg;
    localparam int D_DEF = 4;
    localparam int OUT_STAGE_BITS = 2;
    localparam int OUT_BYTES = 16;
    typedef enum logic [OUT_STAGE_BITS-1:0] {IDLE, REDUCE, MAP, DONE} clm_out_stages_t;
    typedef logic [0:8] base_poly_t;
    typedef logic [0:7][0:7] mm_matrix_t;
endpackage

// File: rtl/clm_output_stage_if.sv
// clm_output_stage_if: request/result bundle between the datapath and the output stage.
interface clm_output_stage_if
    import clm_output_stage_pkg::*;
#(
    parameter int d = D_DEF
);
    logic drdy_i;
    logic [0:3][0:3][0:7+d] state_in;
    base_poly_t P;
    mm_matrix_t L_inv;
    logic [0:127] ciphertext;
    logic drdy_o;
    logic busy;
    modport master(output drdy_i, state_in, P, L_inv, input ciphertext, drdy_o, busy);
    modport slave(input drdy_i, state_in, P, L_inv, output ciphertext, drdy_o, busy);
endinterface

// File: rtl/clm_output_stage_lmap.sv
// clm_lmap: combinational GF(2) 8x8 matrix times 8-bit vector, row i gives bit i.
module clm_lmap
    import clm_output_stage_pkg::*;
(
    input  mm_matrix_t  m,
    input  logic [0:7]  v,
    output logic [0:7]  y
);
    for (genvar i = 0; i < 8; i++) begin : g_row
        assign y[i] = ^(m[i] & v);
    end
endmodule

// File: rtl/clm_output_stage.sv
// clm_output_stage: byte-serial mod-P reduction of the redundant state and
// basis change through L_inv into the 128-bit ciphertext.
module clm_output_stage
    import clm_output_stage_pkg::*;
#(
    parameter int d = D_DEF
) (
    input logic clk,
    input logic rst,
    clm_output_stage_if.slave bus
);
    localparam int W = 8 + d;
    localparam int SW = $clog2(d) + 1;

    clm_out_stages_t state;
    logic [0:3][0:3][0:W-1] st;
    base_poly_t p;
    mm_matrix_t l;
    logic [0:W-1] w;
    logic [0:W-1] pm;
    logic [3:0] byte_ctr;
    logic [3:0] next_byte;
    logic [SW-1:0] step_ctr;
    logic [0:7] rem;
    logic [0:7] y;

    // P aligned so its x^8 coefficient sits under w[step_ctr]
    assign pm = (W'(p) << (d - 1)) >> step_ctr;
    assign rem = w[d +: 8];
    assign next_byte = byte_ctr + 4'd1;

    clm_lmap u_lmap (.m(l), .v(rem), .y(y));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            st <= '0;
            p <= '0;
            l <= '0;
            w <= '0;
            byte_ctr <= '0;
            step_ctr <= '0;
            bus.ciphertext <= '0;
            bus.drdy_o <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            bus.drdy_o <= 1'b0;
            case (state)
                IDLE: if (bus.drdy_i) begin
                    st <= bus.state_in;
                    p <= bus.P;
                    l <= bus.L_inv;
                    w <= bus.state_in[0][0];
                    byte_ctr <= '0;
                    step_ctr <= '0;
                    bus.busy <= 1'b1;
                    state <= (d == 0) ? MAP : REDUCE;
                end
                REDUCE: begin
                    w <= w ^ (w[step_ctr] ? pm : '0);
                    step_ctr <= step_ctr + 1'b1;
                    if (step_ctr == SW'(d - 1)) state <= MAP;
                end
                MAP: begin
                    bus.ciphertext[{byte_ctr, 3'b000} +: 8] <= y;
                    if (byte_ctr == 4'(OUT_BYTES - 1)) begin
                        bus.drdy_o <= 1'b1;
                        state <= DONE;
                    end else begin
                        byte_ctr <= next_byte;
                        w <= st[next_byte[3:2]][next_byte[1:0]];
                        step_ctr <= '0;
                        state <= (d == 0) ? MAP : REDUCE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clm_output_stage.sv
// tb_clm_output_stage: vector table plus random runs against a polynomial-division reference model.
module tb_clm_output_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0;
    int fails = 0;
    int lat;
    int cnt;
    logic [11:0] e [16];
    logic [8:0] p;
    logic [7:0] l [8];
    logic [127:0] exp_ct;

    typedef struct {
        logic [11:0] e0, e1, er;
        logic anti;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl [3];

    always #5 clk = ~clk;

    clm_output_stage_if #(.d(4)) bus ();
    clm_output_stage #(.d(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    // element value is a polynomial with x^n at numeric bit n; divide from the top degree down
    function automatic logic [127:0] model(input logic [11:0] ev [16], input logic [8:0] pv, input logic [7:0] lv [8]);
        logic [127:0] res = '0;
        for (int k = 0; k < 16; k++) begin
            logic [11:0] v = ev[k];
            logic [7:0] b;
            for (int n = 11; n >= 8; n--) if (v[n]) v ^= 12'(pv) << (n - 8);
            for (int i = 0; i < 8; i++) b[7-i] = ^(lv[i] & v[7:0]);
            res[127-8*k -: 8] = b;
        end
        return res;
    endfunction

    task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < 16; k++) bus.state_in[k/4][k%4] = e[k];
        bus.P = p;
        for (int i = 0; i < 8; i++) bus.L_inv[i] = l[i];
    endtask

    task automatic randomize_stim();
        for (int k = 0; k < 16; k++) e[k] = 12'($urandom);
        p = {1'b1, 8'($urandom)};
        for (int i = 0; i < 8; i++) l[i] = 8'($urandom);
    endtask

    task automatic run(input bit scr, input bit inj, output int lt);
        @(negedge clk);
        bus.drdy_i = 1'b1;
        @(negedge clk);
        bus.drdy_i = 1'b0;
        check("busy_rise", 128'(bus.busy), 128'd1);
        if (scr) begin
            for (int k = 0; k < 16; k++) bus.state_in[k/4][k%4] = 12'($urandom);
            bus.P = {1'b1, 8'($urandom)};
            for (int i = 0; i < 8; i++) bus.L_inv[i] = 8'($urandom);
        end
        lt = 0;
        while (!bus.drdy_o && lt < 200) begin
            @(negedge clk);
            lt++;
            bus.drdy_i = inj && lt == 2;
        end
        check("latency", 128'(lt), 128'd80);
        bus.drdy_i = inj;
        @(negedge clk);
        bus.drdy_i = 1'b0;
        check("pulse_end", 128'({bus.drdy_o, bus.busy}), 128'd0);
    endtask

    initial begin
        tbl[0] = '{12'h0A5, 12'h0A5, 12'h0A5, 1'b0, {16{8'hA5}}};
        tbl[1] = '{12'h100, 12'h800, 12'h000, 1'b0, {8'h1B, 8'hD8, 112'h0}};
        tbl[2] = '{12'h001, 12'h001, 12'h001, 1'b1, {16{8'h80}}};
        bus.drdy_i = 1'b0;
        for (int k = 0; k < 16; k++) e[k] = '0;
        p = 9'h11B;
        for (int i = 0; i < 8; i++) l[i] = 8'h80 >> i;
        apply();
        repeat (3) @(negedge clk);
        check("reset_ct", 128'(bus.ciphertext), 128'd0);
        check("reset_drdy", 128'(bus.drdy_o), 128'd0);
        check("reset_busy", 128'(bus.busy), 128'd0);
        rst = 1'b1;

        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 16; k++) e[k] = (k == 0) ? tbl[t].e0 : (k == 1) ? tbl[t].e1 : tbl[t].er;
            p = 9'h11B;
            for (int i = 0; i < 8; i++) l[i] = tbl[t].anti ? 8'h01 << i : 8'h80 >> i;
            apply();
            run(1'b0, 1'b0, lat);
            check($sformatf("vec%0d", t), 128'(bus.ciphertext), tbl[t].exp);
        end

        for (int r = 0; r < 6; r++) begin
            randomize_stim();
            apply();
            exp_ct = model(e, p, l);
            run(1'b0, 1'b0, lat);
            check($sformatf("rand%0d", r), 128'(bus.ciphertext), exp_ct);
        end

        randomize_stim();
        apply();
        exp_ct = model(e, p, l);
        run(1'b1, 1'b0, lat);
        check("scramble", 128'(bus.ciphertext), exp_ct);

        for (int k = 0; k < 16; k++) e[k] = 12'h0A5;
        p = 9'h11B;
        for (int i = 0; i < 8; i++) l[i] = 8'h80 >> i;
        apply();
        run(1'b0, 1'b1, lat);
        check("inj_ct", 128'(bus.ciphertext), {16{8'hA5}});
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.drdy_o) cnt++;
        end
        check("no_restart", 128'(cnt), 128'd0);
        check("inj_idle", 128'(bus.busy), 128'd0);

        randomize_stim();
        apply();
        @(negedge clk);
        bus.drdy_i = 1'b1;
        @(negedge clk);
        bus.drdy_i = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ct", 128'(bus.ciphertext), 128'd0);
        check("abort_busy", 128'(bus.busy), 128'd0);
        check("abort_drdy", 128'(bus.drdy_o), 128'd0);
        rst = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.drdy_o) cnt++;
        end
        check("abort_no_drdy", 128'(cnt), 128'd0);
        randomize_stim();
        apply();
        exp_ct = model(e, p, l);
        run(1'b0, 1'b0, lat);
        check("after_abort", 128'(bus.ciphertext), exp_ct);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
